// File: rtl/regbank_pkg.sv
// Shared types and constants for the 8x8-bit register bank, its write-back front end
// and the issue logic that queries it.
package regbank_pkg;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back buffer of wb_entry_t. Exposes its raw storage and a per-slot valid
// vector so the parent can run an associative forwarding search.
module wb_fifo
    import regbank_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  wb_entry_t             din_i,
    output wb_entry_t             head_o,
    output wb_entry_t [DEPTH-1:0] entries_o,
    output logic      [DEPTH-1:0] slot_valid_o,
    output logic      [PTR_W-1:0] rd_ptr_o,
    output logic      [CNT_W-1:0] count_o,
    output logic                  empty_o
);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic      [PTR_W-1:0] rd_ptr_q;
    logic      [PTR_W-1:0] wr_ptr_q;
    logic      [CNT_W-1:0] count_q;
    logic      [PTR_W-1:0] slot_off;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_i && pop_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: slot_valid masks every stale slot.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        slot_off     = '0;
        slot_valid_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off        = PTR_W'(i) - rd_ptr_q;
            slot_valid_o[i] = CNT_W'(slot_off) < count_q;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/regbank_writeback.sv
// Write-side front end of the register bank: buffers results, drains one write per cycle,
// and publishes a per-register busy scoreboard plus two forwarding lookup ports.
module regbank_writeback
    import regbank_pkg::wb_entry_t;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = regbank_pkg::DATA_W,
    parameter int unsigned ADDR_W = regbank_pkg::ADDR_W,
    localparam int unsigned NUM_REGS = 2 ** ADDR_W,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [ADDR_W-1:0]   res_addr,
    input  logic [DATA_W-1:0]   res_data,
    input  logic                wb_stall,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy,
    input  logic [ADDR_W-1:0]   q_addr1,
    output logic                q_hit1,
    output logic [DATA_W-1:0]   q_data1,
    input  logic [ADDR_W-1:0]   q_addr2,
    output logic                q_hit2,
    output logic [DATA_W-1:0]   q_data2
);

    wb_entry_t             fifo_din;
    wb_entry_t             fifo_head;
    wb_entry_t [DEPTH-1:0] fifo_entries;
    logic      [DEPTH-1:0] fifo_valid;
    logic      [PTR_W-1:0] fifo_rd_ptr;
    logic      [CNT_W-1:0] fifo_count;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic      [PTR_W-1:0] fwd_idx;
    logic      [CNT_W-1:0] cnt_q [NUM_REGS];
    logic      [CNT_W-1:0] cnt_d [NUM_REGS];

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign res_ready = !rst && !flush && (fifo_count != CNT_W'(DEPTH));
    assign push      = res_valid && res_ready;
    assign wr_en     = !fifo_empty && !wb_stall && !rst && !flush;
    assign pop       = wr_en;
    assign fifo_din  = '{addr: res_addr, data: res_data};
    assign wr_addr   = (fifo_empty || rst) ? '0 : fifo_head.addr;
    assign wr_data   = (fifo_empty || rst) ? '0 : fifo_head.data;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .push_i      (push),
        .pop_i       (pop),
        .din_i       (fifo_din),
        .head_o      (fifo_head),
        .entries_o   (fifo_entries),
        .slot_valid_o(fifo_valid),
        .rd_ptr_o    (fifo_rd_ptr),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    // Push and pop to the same register cancel out.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (push && (res_addr == ADDR_W'(r))) begin
                cnt_d[r] = cnt_d[r] + CNT_W'(1);
            end
            if (pop && (fifo_head.addr == ADDR_W'(r))) begin
                cnt_d[r] = cnt_d[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy[r] = !rst && (cnt_q[r] != '0);
        end
    end

    // Scan oldest to youngest so the last match, the youngest write, wins.
    always_comb begin
        q_hit1  = 1'b0;
        q_data1 = '0;
        q_hit2  = 1'b0;
        q_data2 = '0;
        fwd_idx = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fwd_idx = fifo_rd_ptr + PTR_W'(i);
                if (fifo_valid[fwd_idx] && (fifo_entries[fwd_idx].addr == q_addr1)) begin
                    q_hit1  = 1'b1;
                    q_data1 = fifo_entries[fwd_idx].data;
                end
                if (fifo_valid[fwd_idx] && (fifo_entries[fwd_idx].addr == q_addr2)) begin
                    q_hit2  = 1'b1;
                    q_data2 = fifo_entries[fwd_idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regbank_writeback.sv
// Self-checking bench for regbank_writeback: directed scenarios plus a randomized run against
// a queue-based model of the pending writes.
module tb_regbank_writeback;

    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       res_valid = 1'b0;
    logic       wb_stall = 1'b0;
    logic [2:0] res_addr = '0;
    logic [7:0] res_data = '0;
    logic [2:0] q_addr1 = '0;
    logic [2:0] q_addr2 = '0;
    logic       res_ready, wr_en, q_hit1, q_hit2;
    logic [2:0] wr_addr;
    logic [7:0] wr_data, q_data1, q_data2, busy;

    int   n_assert = 0;
    int   n_fail = 0;
    bit   inv_en = 1'b0;
    int   inv_sum;
    ent_t m_q[$];

    always #5 clk = ~clk;

    regbank_writeback #(
        .DEPTH (DEPTH),
        .DATA_W(8),
        .ADDR_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_addr (res_addr),
        .res_data (res_data),
        .wb_stall (wb_stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .q_addr1  (q_addr1),
        .q_hit1   (q_hit1),
        .q_data1  (q_data1),
        .q_addr2  (q_addr2),
        .q_hit2   (q_hit2),
        .q_data2  (q_data2)
    );

    // Reference model: the pending writes are simply a queue in acceptance order.
    function automatic bit m_ready();
        return !rst && !flush && (m_q.size() < DEPTH);
    endfunction

    function automatic bit m_wren();
        return (m_q.size() > 0) && !wb_stall && !rst && !flush;
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] b = '0;
        if (!rst) foreach (m_q[i]) b[m_q[i].a] = 1'b1;
        return b;
    endfunction

    function automatic void m_fwd(input logic [2:0] a, output logic hit, output logic [7:0] d);
        hit = 1'b0;
        d   = '0;
        if (!rst) begin
            foreach (m_q[i]) begin
                if (m_q[i].a == a) begin
                    hit = 1'b1;
                    d   = m_q[i].d;
                end
            end
        end
    endfunction

    task automatic tick();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = m_ready() && res_valid;
        do_pop  = m_wren();
        e.a = res_addr;
        e.d = res_data;
        @(posedge clk);
        if (rst || flush) begin
            m_q.delete();
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(e);
        end
        #2;
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            inv_sum = 0;
            for (int r = 0; r < 8; r++) inv_sum += int'(dut.cnt_q[r]);
            n_assert++;
            if (inv_sum != int'(dut.fifo_count) || inv_sum != m_q.size()) begin
                n_fail++;
                $display("FAIL invariant t=%0t: cnt sum %0d count %0d, required both %0d",
                         $time, inv_sum, dut.fifo_count, m_q.size());
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; res_valid = 1'b1; res_addr = 3'd1; res_data = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            tick();
            inv_en = 1'b1;
            n_assert++;
            if (res_ready !== 1'b0) begin n_fail++; $display("FAIL reset.ready got %b exp 0", res_ready); end
            n_assert++;
            if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset.wr_en got %b exp 0", wr_en); end
            n_assert++;
            if (busy !== 8'h00) begin n_fail++; $display("FAIL reset.busy got %h exp 00", busy); end
        end
        rst = 1'b0; res_valid = 1'b0;
        #1;
        n_assert++;
        if (res_ready !== 1'b1) begin n_fail++; $display("FAIL reset.release_ready got %b exp 1", res_ready); end
        n_assert++;
        if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset.nothing_taken got %b exp 0", wr_en); end
    endtask

    task automatic test_single();
        res_valid = 1'b1; res_addr = 3'd3; res_data = 8'h5A; q_addr1 = 3'd3;
        #1;
        n_assert++;
        if (res_ready !== 1'b1) begin n_fail++; $display("FAIL single.ready got %b exp 1", res_ready); end
        tick();
        res_valid = 1'b0;
        #1;
        n_assert++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd3, 8'h5A}) begin
            n_fail++; $display("FAIL single.write got %b/%0d/%h exp 1/3/5a", wr_en, wr_addr, wr_data);
        end
        n_assert++;
        if (busy !== 8'h08) begin n_fail++; $display("FAIL single.busy got %h exp 08", busy); end
        n_assert++;
        if ({q_hit1, q_data1} !== {1'b1, 8'h5A}) begin
            n_fail++; $display("FAIL single.fwd_popping got %b/%h exp 1/5a", q_hit1, q_data1);
        end
        tick();
        #1;
        n_assert++;
        if ({wr_en, busy} !== {1'b0, 8'h00}) begin
            n_fail++; $display("FAIL single.drained got %b/%h exp 0/00", wr_en, busy);
        end
    endtask

    task automatic test_stall_full();
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_addr = 3'(i + 1); res_data = 8'(i + 1);
            #1;
            n_assert++;
            if (res_ready !== 1'b1) begin n_fail++; $display("FAIL full.fill_ready[%0d] got %b exp 1", i, res_ready); end
            tick();
        end
        res_addr = 3'd5; res_data = 8'h05;
        #1;
        n_assert++;
        if ({res_ready, wr_en, busy} !== {1'b0, 1'b0, 8'h1E}) begin
            n_fail++; $display("FAIL full.held got ready %b wr_en %b busy %h exp 0 0 1e", res_ready, wr_en, busy);
        end
        tick();
        wb_stall = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_assert++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'(k + 1), 8'(k + 1)}) begin
                n_fail++; $display("FAIL full.drain[%0d] got %b/%0d/%h exp 1/%0d/%0h", k, wr_en, wr_addr, wr_data, k + 1, k + 1);
            end
            if (k < 2) begin
                n_assert++;
                if (res_ready !== (k == 1)) begin
                    n_fail++; $display("FAIL full.ready_after_pop[%0d] got %b exp %b", k, res_ready, k == 1);
                end
            end
            tick();
            if (k == 1) res_valid = 1'b0;
            #1;
        end
        n_assert++;
        if (wr_en !== 1'b0) begin n_fail++; $display("FAIL full.empty_after got %b exp 0", wr_en); end
    endtask

    task automatic test_forward();
        wb_stall = 1'b1; res_valid = 1'b1; res_addr = 3'd2; res_data = 8'h11;
        tick();
        res_data = 8'h22;
        tick();
        res_valid = 1'b0; q_addr1 = 3'd2; q_addr2 = 3'd5;
        #1;
        n_assert++;
        if ({q_hit1, q_data1} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL fwd.youngest got %b/%h exp 1/22", q_hit1, q_data1); end
        n_assert++;
        if ({q_hit2, q_data2} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL fwd.miss got %b/%h exp 0/00", q_hit2, q_data2); end
        n_assert++;
        if (busy !== 8'h04) begin n_fail++; $display("FAIL fwd.busy got %h exp 04", busy); end
        wb_stall = 1'b0;
        tick();
        #1;
        n_assert++;
        if ({q_hit1, q_data1, busy[2]} !== {1'b1, 8'h22, 1'b1}) begin
            n_fail++; $display("FAIL fwd.after_pop1 got %b/%h/%b exp 1/22/1", q_hit1, q_data1, busy[2]);
        end
        tick();
        #1;
        n_assert++;
        if ({q_hit1, q_data1, busy[2]} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL fwd.after_pop2 got %b/%h/%b exp 0/00/0", q_hit1, q_data1, busy[2]);
        end
    endtask

    task automatic test_flush();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_addr = 3'((6 + i) % 8); res_data = 8'hA0 + 8'((6 + i) % 8);
            tick();
        end
        wb_stall = 1'b0; flush = 1'b1; res_addr = 3'd1; res_data = 8'hB1; q_addr1 = 3'd6;
        #1;
        n_assert++;
        if ({wr_en, res_ready} !== 2'b00) begin
            n_fail++; $display("FAIL flush.cycle got wr_en %b ready %b exp 0 0", wr_en, res_ready);
        end
        tick();
        flush = 1'b0; res_valid = 1'b0;
        #1;
        n_assert++;
        if ({busy, q_hit1, res_ready} !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL flush.cleared got busy %h hit %b ready %b exp 00 0 1", busy, q_hit1, res_ready);
        end
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (wr_en !== 1'b0) begin n_fail++; $display("FAIL flush.no_write[%0d] got %b exp 0", i, wr_en); end
            tick();
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            res_valid = 1'b1; res_addr = 3'(i % 8); res_data = 8'(8'h80 + i);
            #1;
            n_assert++;
            if (res_ready !== 1'b1) begin n_fail++; $display("FAIL stream.ready[%0d] got %b exp 1", i, res_ready); end
            n_assert++;
            if (i == 0) begin
                if (wr_en !== 1'b0) begin n_fail++; $display("FAIL stream.first got %b exp 0", wr_en); end
            end else if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'((i - 1) % 8), 8'(8'h80 + i - 1)}) begin
                n_fail++; $display("FAIL stream.write[%0d] got %b/%0d/%h exp 1/%0d/%0h",
                                   i, wr_en, wr_addr, wr_data, (i - 1) % 8, 8'h80 + i - 1);
            end
            tick();
        end
        res_valid = 1'b0;
        #1;
        n_assert++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd1, 8'h89}) begin
            n_fail++; $display("FAIL stream.last got %b/%0d/%h exp 1/1/89", wr_en, wr_addr, wr_data);
        end
        tick();
        #1;
        n_assert++;
        if (wr_en !== 1'b0) begin n_fail++; $display("FAIL stream.idle got %b exp 0", wr_en); end
    endtask

    task automatic test_random();
        logic       eh1, eh2;
        logic [7:0] ed1, ed2;
        logic [2:0] ea;
        logic [7:0] edat;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(99) == 0);
            flush     = ($urandom_range(29) == 0);
            res_valid = ($urandom_range(1) == 1);
            wb_stall  = ($urandom_range(3) == 0);
            res_addr  = 3'($urandom_range(7));
            res_data  = 8'($urandom);
            q_addr1   = 3'($urandom_range(7));
            q_addr2   = 3'($urandom_range(7));
            #1;
            m_fwd(q_addr1, eh1, ed1);
            m_fwd(q_addr2, eh2, ed2);
            ea   = (rst || m_q.size() == 0) ? 3'd0 : m_q[0].a;
            edat = (rst || m_q.size() == 0) ? 8'd0 : m_q[0].d;
            n_assert++;
            if (res_ready !== m_ready()) begin n_fail++; $display("FAIL rand.ready c%0d got %b exp %b", c, res_ready, m_ready()); end
            n_assert++;
            if (wr_en !== m_wren()) begin n_fail++; $display("FAIL rand.wr_en c%0d got %b exp %b", c, wr_en, m_wren()); end
            n_assert++;
            if ({wr_addr, wr_data} !== {ea, edat}) begin
                n_fail++; $display("FAIL rand.head c%0d got %0d/%h exp %0d/%h", c, wr_addr, wr_data, ea, edat);
            end
            n_assert++;
            if (busy !== m_busy()) begin n_fail++; $display("FAIL rand.busy c%0d got %h exp %h", c, busy, m_busy()); end
            n_assert++;
            if ({q_hit1, q_data1} !== {eh1, ed1}) begin
                n_fail++; $display("FAIL rand.fwd1 c%0d got %b/%h exp %b/%h", c, q_hit1, q_data1, eh1, ed1);
            end
            n_assert++;
            if ({q_hit2, q_data2} !== {eh2, ed2}) begin
                n_fail++; $display("FAIL rand.fwd2 c%0d got %b/%h exp %b/%h", c, q_hit2, q_data2, eh2, ed2);
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0; res_valid = 1'b0; wb_stall = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stall_full();
        test_forward();
        test_flush();
        test_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_writeback.md
Name: regbank_writeback

Overview:
Write-side front end of the 8x8-bit register bank. It accepts result writes (dest address + data) from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO. It drains one write per cycle into the register bank write port. It exports a per-register busy scoreboard and a two-port forwarding lookup, so issue logic can detect hazards and read values that are still pending.

Parameters:
DEPTH, 4, number of buffered write entries (power of two, >=2)
DATA_W, 8, register data width
ADDR_W, 3, register address width (NUM_REGS = 2**ADDR_W = 8)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous discard of all pending writes
res_valid  in  1  producer has a result
res_ready  out  1  block can accept a result this cycle
res_addr  in  ADDR_W  destination register
res_data  in  DATA_W  result value
wb_stall  in  1  register bank cannot take a write this cycle
wr_en  out  1  write strobe to register bank
wr_addr  out  ADDR_W  write address (addrdest)
wr_data  out  DATA_W  write data (datadest)
busy  out  NUM_REGS  bit r = at least one pending write to register r
q_addr1  in  ADDR_W  forwarding query, port 1
q_hit1  out  1  pending write to q_addr1 exists
q_data1  out  DATA_W  data of youngest pending write to q_addr1, else 0
q_addr2, q_hit2, q_data2  same as port 1, second query

Behaviour:
- Reset (rst=1 at a clock edge): FIFO empty, read/write pointers 0, count 0, all per-register pending counters 0. While rst is high: res_ready=0, wr_en=0, busy=0, q_hit*=0, q_data*=0, wr_addr=0, wr_data=0. rst has priority over flush and over every handshake.
- Accept: push = res_valid & res_ready. res_ready = !rst & !flush & (count != DEPTH). A push is never accepted when full, even if a pop occurs in the same cycle.
- Drain: wr_en = !empty & !wb_stall & !rst & !flush. wr_addr and wr_data are combinational from the FIFO head and read 0 when empty. Pop = wr_en.
- Latency: an entry pushed at edge N appears on the write port in cycle N+1 at the earliest. There is no combinational pass-through from res_* to wr_*.
- Ordering: strict FIFO. Two writes to the same register reach the bank in acceptance order.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Scoreboard: one pending counter per register, width clog2(DEPTH+1).
  - Increment on push to that address; decrement on pop from that address.
  - Push and pop to the same register in the same cycle: counter unchanged.
  - busy[r] = (cnt[r] != 0), registered-state derived. busy reflects a push from the next cycle onward.
- Forwarding: combinational search over valid FIFO entries, excluding the same-cycle incoming push.
  - The youngest matching entry wins.
  - An entry popped this cycle still counts as a hit this cycle.
  - No match: hit=0, data=0.
- Flush: at the edge, clears the FIFO and all counters exactly like reset. During the flush cycle, wr_en=0 and res_ready=0, so nothing is written and nothing is accepted.
- wb_stall only holds the head entry and never drops it. busy and forwarding remain valid while stalled.
- Invariant: sum of cnt[r] == count at all times. A bench assertion checks this.

Decomposition:
- Package regbank_pkg: ADDR_W=3, DATA_W=8, NUM_REGS=8 constants; wb_entry_t struct {addr, data}; shared with the register bank and issue logic.
- Sub-module wb_fifo:
  - Parameterised DEPTH storage of wb_entry_t with push/pop/flush, count, full/empty.
  - Exposes its entry array plus a per-slot valid vector for the forwarding search.
  - Scoreboard and forwarding stay in regbank_writeback.

Test Plan:
1. Hold rst high for 2 cycles with res_valid=1 -> res_ready=0, wr_en=0, busy=0x00. After release -> res_ready=1, nothing was accepted.
2. Push (addr 3, data 0x5A) at edge N with wb_stall=0 -> cycle N+1: wr_en=1, wr_addr=3, wr_data=0x5A, busy=0x08. Cycle N+2: busy=0x00, wr_en=0.
3. Set wb_stall=1 and push 4 entries (1,0x01)..(4,0x04) -> res_ready=0 with 5th entry held; busy=0x1E. Drop stall -> writes 1,2,3,4 in consecutive cycles; res_ready=1 from the cycle after the first pop; 5th entry accepted then written last.
4. Stall and push (2,0x11) then (2,0x22); q_addr1=2, q_addr2=5 -> q_hit1=1, q_data1=0x22, q_hit2=0, q_data2=0. Unstall -> after first pop q_data1=0x22 and busy[2]=1; after second pop busy[2]=0, q_hit1=0.
5. With 3 entries pending, assert flush one cycle -> wr_en=0 and res_ready=0 in that cycle; next cycle count=0, busy=0x00, no write of the discarded entries ever appears.
6. Stream 10 pushes with continuous drain, to regs 0..7 then 0,1 with data 0x80+i -> each write appears exactly 1 cycle after its push, count stays <=1, pointers wrap twice, counter-sum invariant holds throughout.
